// File: rtl/ram_readback.sv
// ---------------------------------------------------------------------------
// ram_readback
//
// Purpose:
//   Walks a synchronous RAM from address 0 up to LAST_ADDR, one word per
//   read, and presents each captured word with its address, a one-cycle
//   capture strobe, a running modulo-2**DATA_W checksum and an active-low
//   display value. Scans run free (one word every two cycles) or advance
//   one word per step pulse, and can be aborted at any point.
//
// Ports:
//   clk         in   the only clock, all logic on its rising edge
//   rst         in   synchronous active-high reset
//   start       in   single-cycle scan request (honoured in IDLE / DONE)
//   abort       in   stops an active scan, returning to IDLE
//   step_mode   in   0 = free-running scan, 1 = one word per step pulse
//   step        in   advance pulse, only looked at while holding
//   rden        out  RAM read enable, high only in the issue cycle
//   rdaddr      out  RAM read address (the internal scan address)
//   rdata       in   RAM read data, valid one cycle after rden
//   busy        out  high while a scan is active
//   done        out  high once a scan has completed, until start or rst
//   cur_addr    out  address of the last captured word
//   cur_data    out  last captured word
//   data_valid  out  one-cycle pulse on each capture
//   checksum    out  running sum of the captured words, wrapping
//   led         out  active-low display value, ~{cur_addr, cur_data}
// ---------------------------------------------------------------------------
module ram_readback #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 8,
    parameter int LAST_ADDR = 63
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     step_mode,
    input  logic                     step,
    output logic                     rden,
    output logic [ADDR_W-1:0]        rdaddr,
    input  logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        cur_addr,
    output logic [DATA_W-1:0]        cur_data,
    output logic                     data_valid,
    output logic [DATA_W-1:0]        checksum,
    output logic [ADDR_W+DATA_W-1:0] led
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_HOLD    = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    // Checksum accumulation: the carry out of the top bit is simply dropped,
    // giving the required modulo-2**DATA_W behaviour.
    function automatic logic [DATA_W-1:0] sum_wrap(
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] word
    );
        return acc + word;
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0]   cur_data_q, cur_data_d;
    logic [DATA_W-1:0]   checksum_q, checksum_d;
    logic                data_valid_q, data_valid_d;

    logic                active;
    logic                start_take;
    logic                abort_take;
    logic                capture;
    logic                at_last;

    // Decoded control conditions shared by the FSM and the datapath.
    always_comb begin
        active     = (state_q == S_ISSUE) || (state_q == S_CAPTURE) ||
                     (state_q == S_HOLD);
        start_take = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        abort_take = abort && active;
        capture    = (state_q == S_CAPTURE);
        at_last    = (addr_q == LAST);
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // An abort here drops the outstanding read: IDLE never
                // captures, so the word arriving next cycle is ignored.
                state_d = abort ? S_IDLE : S_CAPTURE;
            end
            S_CAPTURE: begin
                // The capture itself still completes on this edge even when
                // aborting; only the continuation is cancelled.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (at_last) begin
                    state_d = S_DONE;
                end else if (step_mode) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (step) begin
                    state_d = S_ISSUE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs decoded from the current state
    // -----------------------------------------------------------------------
    always_comb begin
        rden = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            S_ISSUE: begin
                rden = 1'b1;
                busy = 1'b1;
            end
            S_CAPTURE, S_HOLD: begin
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                rden = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Scan address: cleared on start, advanced only when a capture hands off
    // to another read, so it parks on LAST_ADDR at the end of a scan.
    // -----------------------------------------------------------------------
    always_comb begin
        addr_d = addr_q;
        if (start_take) begin
            addr_d = '0;
        end else if (capture && !abort_take && !at_last) begin
            addr_d = addr_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Capture datapath: word, address, strobe and running checksum.
    // -----------------------------------------------------------------------
    always_comb begin
        cur_addr_d   = cur_addr_q;
        cur_data_d   = cur_data_q;
        checksum_d   = checksum_q;
        data_valid_d = 1'b0;
        if (start_take) begin
            cur_addr_d = '0;
            cur_data_d = '0;
            checksum_d = '0;
        end else if (capture) begin
            cur_addr_d   = addr_q;
            cur_data_d   = rdata;
            checksum_d   = sum_wrap(checksum_q, rdata);
            data_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            cur_addr_q   <= '0;
            cur_data_q   <= '0;
            checksum_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            cur_addr_q   <= cur_addr_d;
            cur_data_q   <= cur_data_d;
            checksum_q   <= checksum_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign rdaddr     = addr_q;
    assign cur_addr   = cur_addr_q;
    assign cur_data   = cur_data_q;
    assign checksum   = checksum_q;
    assign data_valid = data_valid_q;
    assign led        = ~{cur_addr_q, cur_data_q};

endmodule

// File: tb/tb_ram_readback.sv
// ---------------------------------------------------------------------------
// tb_ram_readback
//
// Directed bench for ram_readback with a 64x8 RAM model (1-cycle registered
// read). Words 0..9 hold 01,AA,55,FF,F0,0F,CC,33,02,04; the rest are 00.
// ---------------------------------------------------------------------------
module tb_ram_readback;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic                     abort = 1'b0;
    logic                     step_mode = 1'b0;
    logic                     step = 1'b0;
    logic                     rden;
    logic [ADDR_W-1:0]        rdaddr;
    logic [DATA_W-1:0]        rdata = '0;
    logic                     busy;
    logic                     done;
    logic [ADDR_W-1:0]        cur_addr;
    logic [DATA_W-1:0]        cur_data;
    logic                     data_valid;
    logic [DATA_W-1:0]        checksum;
    logic [ADDR_W+DATA_W-1:0] led;

    int n_checks = 0;
    int n_errors = 0;
    int dv_cnt   = 0;

    logic [DATA_W-1:0] mem [0:63];

    ram_readback #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LAST_ADDR(63)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .step_mode (step_mode),
        .step      (step),
        .rden      (rden),
        .rdaddr    (rdaddr),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .cur_addr  (cur_addr),
        .cur_data  (cur_data),
        .data_valid(data_valid),
        .checksum  (checksum),
        .led       (led)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[0] = 8'h01; mem[1] = 8'hAA; mem[2] = 8'h55; mem[3] = 8'hFF;
        mem[4] = 8'hF0; mem[5] = 8'h0F; mem[6] = 8'hCC; mem[7] = 8'h33;
        mem[8] = 8'h02; mem[9] = 8'h04;
    end

    always @(posedge clk) begin
        if (rden) rdata <= mem[rdaddr];
    end

    always @(negedge clk) begin
        if (data_valid) dv_cnt <= dv_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs from just after the start edge until done, returning the cycle
    // count. With inject set, stray start/step pulses land mid-scan.
    task automatic run_scan(input bit inject, output int cyc);
        cyc = 0;
        while (!done && cyc < 300) begin
            if (inject) begin
                start = (cyc == 20) || (cyc == 70) || (cyc == 101);
                step  = (cyc == 41) || (cyc == 70) || (cyc == 102);
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        step  = 1'b0;
    endtask

    task automatic wait_dv(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!data_valid && n < 10);
        chk(tag, data_valid, 1);
    endtask

    // Bounded wait for a given read address in the issue (want_rden=1) or
    // capture (want_rden=0) cycle of a free-running scan.
    task automatic wait_addr(input string tag, input logic [ADDR_W-1:0] a, input logic want_rden);
        int n;
        n = 0;
        while (!(busy && rden == want_rden && rdaddr == a) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, (busy && rden == want_rden && rdaddr == a), 1);
    endtask

    initial begin
        int cyc;
        int dv_base;
        int rd_seen;
        logic [7:0] step_exp [0:3];
        step_exp[0] = 8'h01; step_exp[1] = 8'hAA;
        step_exp[2] = 8'h55; step_exp[3] = 8'hFF;

        // ---- reset state ----
        repeat (3) tick();
        chk("rst_rden", rden, 0);
        chk("rst_rdaddr", rdaddr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_cur_addr", cur_addr, 0);
        chk("rst_cur_data", cur_data, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_led", led, 32'h3FFF);
        rst = 1'b0;
        tick();

        // ---- free-running full scan ----
        step_mode = 1'b0;
        dv_base = dv_cnt;
        pulse_start();
        chk("free_first_issue", {busy, rden, 2'b00, 2'b00, rdaddr}, {1'b1, 1'b1, 4'b0000, 6'd0});
        run_scan(1'b0, cyc);
        chk("free_done_latency", cyc, 128);
        chk("free_done", done, 1);
        chk("free_checksum", checksum, 8'h03);
        chk("free_cur_addr", cur_addr, 63);
        chk("free_cur_data", cur_data, 8'h00);
        tick();
        chk("free_dv_count", dv_cnt - dv_base, 64);
        chk("free_done_holds", {busy, done, rden}, 3'b010);

        // ---- restart from DONE with stray start/step pulses mid-scan ----
        dv_base = dv_cnt;
        pulse_start();
        chk("restart_done_clr", done, 0);
        chk("restart_checksum_clr", checksum, 0);
        chk("restart_rdaddr", rdaddr, 0);
        chk("restart_rden", rden, 1);
        chk("restart_cur", {cur_addr, cur_data}, 0);
        run_scan(1'b1, cyc);
        chk("inject_done_latency", cyc, 128);
        chk("inject_checksum", checksum, 8'h03);
        tick();
        chk("inject_dv_count", dv_cnt - dv_base, 64);

        // ---- step mode: start with step held, then three step pulses ----
        step_mode = 1'b1;
        step = 1'b1;
        pulse_start();
        step = 1'b0;
        wait_dv("step0_dv");
        chk("step0_data", cur_data, step_exp[0]);
        repeat (3) tick();
        chk("hold_wait", {busy, rden, data_valid}, 3'b100);
        chk("hold_rdaddr", rdaddr, 1);
        for (int i = 1; i < 4; i++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            wait_dv("step_dv");
            chk("step_data", cur_data, step_exp[i]);
            chk("step_addr", cur_addr, i);
        end
        repeat (4) tick();
        chk("step_hold_busy", busy, 1);
        chk("step_hold_cur_addr", cur_addr, 3);
        chk("step_checksum", checksum, 8'hFF);

        // abort together with step while holding: abort wins
        abort = 1'b1;
        step  = 1'b1;
        tick();
        abort = 1'b0;
        step  = 1'b0;
        chk("hold_abort_state", {busy, done, rden}, 3'b000);
        chk("hold_abort_keep", {cur_addr, cur_data, checksum}, {6'd3, 8'hFF, 8'hFF});
        tick();
        chk("hold_abort_idle", {busy, rden}, 2'b00);

        // abort ignored in IDLE
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_ignored", {busy, done, cur_data}, {1'b0, 1'b0, 8'hFF});

        // ---- abort during CAPTURE of address 5 ----
        step_mode = 1'b0;
        pulse_start();
        wait_addr("cap5_reach", 6'd5, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("cap5_idle", {busy, done, rden}, 3'b000);
        chk("cap5_cur_data", cur_data, 8'h0F);
        chk("cap5_cur_addr", cur_addr, 5);
        chk("cap5_checksum", checksum, 8'hFE);
        chk("cap5_led", led, 32'h3AF0);
        rd_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rden) rd_seen++;
        end
        chk("cap5_no_rden", rd_seen, 0);
        chk("cap5_done_low", done, 0);

        // ---- abort during ISSUE of address 2: read discarded ----
        pulse_start();
        wait_addr("iss2_reach", 6'd2, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("iss2_idle", {busy, data_valid}, 2'b00);
        tick();
        chk("iss2_no_capture", data_valid, 0);
        chk("iss2_keep", {cur_data, checksum}, {8'hAA, 8'hAB});

        // ---- reset in ISSUE of address 7, with start and abort also high ----
        pulse_start();
        wait_addr("rst7_reach", 6'd7, 1'b1);
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        chk("rst7_ctrl", {rden, busy, done, data_valid}, 4'b0000);
        chk("rst7_rdaddr", rdaddr, 0);
        chk("rst7_cur", {cur_addr, cur_data, checksum}, 0);
        chk("rst7_led", led, 32'h3FFF);
        tick();
        chk("rst_over_start", {rden, busy}, 2'b00);
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_readback.md
RAM_READBACK -- requirements
Module: ram_readback

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter LAST_ADDR, default 63, final address scanned (0 <= LAST_ADDR <= 2**ADDR_W-1).
REQ-004 SHALL have port clk, input, 1, the only clock; all logic on posedge clk.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, single-cycle scan request.
REQ-007 SHALL have port abort, input, 1, stops an active scan.
REQ-008 SHALL have port step_mode, input, 1: 0 = free-running scan, 1 = one word per step pulse.
REQ-009 SHALL have port step, input, 1, advance pulse used in step mode.
REQ-010 SHALL have port rden, output, 1, RAM read enable.
REQ-011 SHALL have port rdaddr, output, ADDR_W, RAM read address.
REQ-012 SHALL have port rdata, input, DATA_W, RAM registered read data.
REQ-013 SHALL have port busy, output, 1, high while a scan is active.
REQ-014 SHALL have port done, output, 1, high once a scan has completed, until the next start or rst.
REQ-015 SHALL have port cur_addr, output, ADDR_W, address of the last captured word.
REQ-016 SHALL have port cur_data, output, DATA_W, last captured word.
REQ-017 SHALL have port data_valid, output, 1, one-cycle pulse on each capture.
REQ-018 SHALL have port checksum, output, DATA_W, running sum of the captured words.
REQ-019 SHALL have port led, output, ADDR_W+DATA_W, active-low display value equal to ~{cur_addr, cur_data}.

Function
REQ-020 SHALL implement the states IDLE, ISSUE, CAPTURE, HOLD and DONE.
REQ-021 SHALL leave IDLE or DONE for ISSUE on start, clearing the internal address, cur_addr, cur_data, checksum and done.
REQ-022 SHALL, in ISSUE, drive rden=1 and rdaddr=internal address for exactly one cycle, then go to CAPTURE.
REQ-023 SHALL treat RAM read latency as 1: rdata is valid in the cycle after rden=1, and CAPTURE registers it at the end of that cycle.
REQ-024 SHALL, in CAPTURE, load cur_data<=rdata and cur_addr<=internal address, pulse data_valid, and update checksum<=(checksum+rdata) mod 2**DATA_W.
REQ-025 SHALL, after CAPTURE, go to DONE when the internal address equals LAST_ADDR, else to HOLD if step_mode=1, else to ISSUE.
REQ-026 SHALL increment the internal address when leaving CAPTURE toward ISSUE or HOLD; the address never wraps past LAST_ADDR.
REQ-027 SHALL, in HOLD, wait for step=1, then go to ISSUE; step_mode is sampled only on leaving CAPTURE.
REQ-028 SHALL hold rden=0 in every state except ISSUE, and hold rdaddr at the internal address at all times.
REQ-029 SHALL assert busy in ISSUE, CAPTURE and HOLD only, and assert done only in DONE.
REQ-030 SHALL, in free-running mode, sustain one word per 2 cycles: done is high 2*(LAST_ADDR+1) cycles after start is sampled.
REQ-031 SHALL ignore start while busy=1.
REQ-032 SHALL ignore step outside HOLD; when start and step arrive together in IDLE, start takes effect and step is ignored.
REQ-033 SHALL, on abort while busy, go to IDLE next cycle with rden=0, keep cur_addr, cur_data and checksum, and leave done=0; abort has priority over step.
REQ-034 SHALL ignore abort in IDLE or DONE.
REQ-035 SHALL discard a read issued in the cycle abort is taken; no capture follows it.

Reset
REQ-036 SHALL, on rst=1 at a clock edge, enter IDLE regardless of state, including mid-scan.
REQ-037 SHALL clear on reset: rden=0, rdaddr=0, busy=0, done=0, data_valid=0, cur_addr=0, cur_data=0, checksum=0; led therefore reads all ones.
REQ-038 SHALL give rst priority over start, abort and step.

Verification
RAM model is 64x8 with 1-cycle registered read; words 0..9 = 01,AA,55,FF,F0,0F,CC,33,02,04 and all other words are 00.
REQ-039 SHALL verify: rst, then start with step_mode=0 -> 64 data_valid pulses, done=1 128 cycles after start, checksum=0x03, cur_addr=63, cur_data=0x00.
REQ-040 SHALL verify: step_mode=1, start, then 3 step pulses -> captures of 01, AA, 55, FF; waits in HOLD with busy=1 and cur_addr=3.
REQ-041 SHALL verify: abort during CAPTURE of address 5 -> IDLE next cycle; cur_data=0x0F; checksum=0xFE; done=0; no further rden.
REQ-042 SHALL verify: rst asserted at address 7 in ISSUE -> the following cycle shows rden=0 and all outputs at reset values.
REQ-043 SHALL verify: start pulsed while busy, and step pulsed in free-running mode -> no effect on the sequence; final checksum is still 0x03.
REQ-044 SHALL verify: start in DONE -> checksum and done clear, and the scan restarts at rdaddr=0.
